serial_carry_adder: RTL and testbench

- Bit-serial ripple-carry adder: the addition counterpart of the 4-bit ripple borrow subtractor.
- Uses a single full-adder cell that processes one operand bit per clock, LSB first, holding the carry in a flop between bits.
- Trades latency for area in the arithmetic datapath.
- Start/busy/done handshake, so a control FSM or testbench can issue back-to-back additions.

---
 rtl/serial_carry_adder_pkg.sv | 12 +
 rtl/serial_carry_adder_full_adder.sv | 14 +
 rtl/serial_carry_adder.sv | 110 +++++++++++
 tb/tb_serial_carry_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_carry_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract family: FSM encoding and default width.
// No logic here; imported by serial_carry_adder and its future borrow-subtractor sibling.
package serial_carry_adder_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ADD  = 1'b1
   } state_e;

endpackage

// File: rtl/serial_carry_adder_full_adder.sv
// One-bit full-adder cell, purely combinational (zero latency, no flow control).
// Dual of the full_sub cell used by the serial borrow subtractor.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_carry_adder.sv
// Bit-serial ripple-carry adder: one full-adder cell, one operand bit per clock, LSB first.
// Latency WIDTH+1 edges from start to done; start is ignored while busy (no queueing).
module serial_carry_adder
   import serial_carry_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
   logic             sum_bit;
   logic             carry_nxt;

   full_adder u_fa (
      .a    (opa_q[0]),
      .b    (opb_q[0]),
      .cin  (carry_q),
      .s    (sum_bit),
      .cout (carry_nxt)
   );

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      s_d     = s_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ADD;
               opa_d   = A;
               opb_d   = B;
               carry_d = Cin;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         ST_ADD: begin
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            carry_d = carry_nxt;
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            acc_d   = (acc_q >> 1) | {sum_bit, {(WIDTH-1){1'b0}}};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = ST_IDLE;
               s_d     = acc_d;
               cout_d  = carry_nxt;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == ST_ADD);
   assign done = done_q;
   assign S    = s_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_serial_carry_adder.sv
// Bench for serial_carry_adder: directed cases on a 4-bit instance, random traffic on an 8-bit one.
// Expected sums come from plain integer addition queued at acceptance; monitors pop on done.
module tb_serial_carry_adder;

   localparam int W4 = 4;
   localparam int W8 = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          st4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
   logic [W4-1:0] a4 = '0, b4 = '0, s4;
   logic          st8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
   logic [W8-1:0] a8 = '0, b8 = '0, s8;

   int n_cmp = 0;
   int n_bad = 0;

   serial_carry_adder #(.WIDTH(W4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(st4), .A(a4), .B(b4), .Cin(cin4),
      .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
   );

   serial_carry_adder #(.WIDTH(W8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8), .Cin(cin8),
      .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: a start is taken only once WIDTH+1 edges have passed since the previous one.
   int rem4 = 0, rem8 = 0;
   int q4[$];
   int q8[$];
   int last4 = 0, last8 = 0;
   bit exp_done4 = 1'b0, exp_done8 = 1'b0;
   int accepted8 = 0, done_cnt4 = 0, done_cnt8 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem4 = 0; rem8 = 0;
         q4.delete(); q8.delete();
         last4 = 0; last8 = 0;
         exp_done4 = 1'b0; exp_done8 = 1'b0;
      end else begin
         exp_done4 = (rem4 == 1);
         if (rem4 > 0) rem4--;
         else if (st4) begin
            q4.push_back(int'(a4) + int'(b4) + int'(cin4));
            rem4 = W4;
         end
         exp_done8 = (rem8 == 1);
         if (rem8 > 0) rem8--;
         else if (st8) begin
            q8.push_back(int'(a8) + int'(b8) + int'(cin8));
            rem8 = W8;
            accepted8++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("busy4", busy4, rem4 > 0);
         check("done4", done4, exp_done4);
         if (done4) begin
            done_cnt4++;
            if (q4.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL done4_unexpected: got done=1, expected no pending result");
            end else begin
               last4 = q4.pop_front();
               check("sum4", {cout4, s4}, last4);
            end
         end else check("hold4", {cout4, s4}, last4);

         check("busy8", busy8, rem8 > 0);
         check("done8", done8, exp_done8);
         if (done8) begin
            done_cnt8++;
            if (q8.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL done8_unexpected: got done=1, expected no pending result");
            end else begin
               last8 = q8.pop_front();
               check("sum8", {cout8, s8}, last8);
            end
         end else check("hold8", {cout8, s8}, last8);
      end
   end

   task automatic run4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic c);
      @(negedge clk);
      a4 = a; b4 = b; cin4 = c; st4 = 1'b1;
      @(negedge clk);
      st4 = 1'b0;
      repeat (W4 + 1) @(negedge clk);
   endtask

   initial begin
      int nb, dpos, first, second, d0, cyc;

      #1;
      check("rst_busy4", busy4, 0);
      check("rst_done4", done4, 0);
      check("rst_sum4", {cout4, s4}, 0);
      check("rst_sum8", {cout8, s8}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 4+5: busy for 4 cycles, done in the 5th
      @(negedge clk);
      a4 = 4'd4; b4 = 4'd5; cin4 = 1'b0; st4 = 1'b1;
      nb = 0; dpos = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) st4 = 1'b0;
         if (busy4) nb++;
         if (done4 && dpos < 0) dpos = i;
      end
      check("t1_busy_cycles", nb, 4);
      check("t1_done_pos", dpos, 5);
      check("t1_sum", {cout4, s4}, 9);

      run4(4'd15, 4'd1, 1'b0);
      check("t2a_sum", {cout4, s4}, 16);
      run4(4'd7, 4'd8, 1'b1);
      check("t2b_sum", {cout4, s4}, 16);
      run4(4'd0, 4'd0, 1'b1);
      check("t2c_sum", {cout4, s4}, 1);

      // start pulsed while busy must be ignored
      d0 = done_cnt4;
      @(negedge clk); a4 = 4'd3; b4 = 4'd2; cin4 = 1'b0; st4 = 1'b1;
      @(negedge clk); st4 = 1'b0;
      @(negedge clk); a4 = 4'd15; b4 = 4'd15; st4 = 1'b1;
      @(negedge clk); st4 = 1'b0;
      repeat (8) @(negedge clk);
      check("t3_done_count", done_cnt4 - d0, 1);
      check("t3_sum", {cout4, s4}, 5);

      // start held: second operands taken in the done cycle
      @(negedge clk); a4 = 4'd6; b4 = 4'd1; cin4 = 1'b0; st4 = 1'b1;
      first = -1; second = -1;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         if (i == 1) begin a4 = 4'd9; b4 = 4'd9; end
         if (i == 6) st4 = 1'b0;
         if (done4) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
      end
      check("t4_first_done", first, 5);
      check("t4_spacing", second - first, 5);
      check("t4_sum", {cout4, s4}, 18);

      // reset in the middle of an addition
      @(negedge clk); a4 = 4'd10; b4 = 4'd10; st4 = 1'b1;
      @(negedge clk); st4 = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy4, 0);
      check("t5_rst_done", done4, 0);
      check("t5_rst_sum", {cout4, s4}, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      run4(4'd1, 4'd2, 1'b0);
      check("t5_sum_after_rst", {cout4, s4}, 3);

      // random traffic on the 8-bit instance; start toggles freely, including while busy
      cyc = 0;
      while (accepted8 < 1000 && cyc < 20000) begin
         @(negedge clk);
         a8 = W8'($urandom);
         b8 = W8'($urandom);
         cin8 = 1'($urandom);
         st8 = ($urandom_range(0, 3) != 0);
         cyc++;
      end
      @(negedge clk); st8 = 1'b0;
      repeat (W8 + 4) @(negedge clk);
      check("t6_accepted", accepted8 >= 1000, 1);
      check("t6_done_vs_accept", done_cnt8, accepted8);
      check("t6_q8_drained", q8.size(), 0);
      check("q4_drained", q4.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
